wbu: RTL
========

WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width of register-file write data and PC.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port inst  input  32  instruction delivered by the LSU stage; rd = inst[11:7], opcode = inst[6:0].
REQ-005 SHALL have port pc  input  XLEN  PC of that instruction.
REQ-006 SHALL have port alu_result  input  XLEN  EXU result forwarded through LSU.
REQ-007 SHALL have port lsu_rdata  input  XLEN  masked, sign/zero-extended load data from LSU.
REQ-008 SHALL have port csr_rdata  input  XLEN  old CSR value for CSR instructions.
REQ-009 SHALL have port wb_sel  input  2  source select: 0 alu_result, 1 lsu_rdata, 2 pc+4, 3 csr_rdata.
REQ-010 SHALL have port reg_wen  input  1  instruction writes rd.
REQ-011 SHALL have port prev_valid / this_ready  input / output  1 each  handshake with LSU.
REQ-012 SHALL have port this_valid / next_ready  output / input  1 each  commit handshake towards IFU.
REQ-013 SHALL have ports rf_wen  output 1, rf_waddr  output 5, rf_wdata  output XLEN  register-file write port.
REQ-014 SHALL have port commit_pc  output  XLEN  PC of the instruction being committed.
REQ-015 SHALL have port commit_cnt  output  64  retired-instruction count (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE and WB; the accept condition is prev_valid & this_ready.
REQ-017 SHALL drive this_ready = (state==IDLE) | (this_valid & next_ready).
REQ-018 SHALL, on accept, register inst rd, pc, reg_wen and the selected write data (pc+4 computed modulo 2^XLEN), then enter WB.
REQ-019 SHALL, in WB, assert rf_wen for exactly the first cycle after accept, only if registered reg_wen=1 and rd!=0.
REQ-020 SHALL hold rf_waddr, rf_wdata, commit_pc stable from accept+1 until the commit handshake.
REQ-021 SHALL assert this_valid throughout WB and hold it until this_valid & next_ready.
REQ-022 SHALL, on commit handshake with no simultaneous accept, return to IDLE with this_valid low next cycle.
REQ-023 SHALL, on commit handshake with simultaneous accept, remain in WB, load the new instruction, and pulse rf_wen again next cycle (back-to-back, 1 instruction/cycle).
REQ-024 SHALL never write the register file twice for one instruction while next_ready is held low.
REQ-025 SHALL ignore all data inputs when no accept occurs.

Reset
REQ-026 SHALL, on rst_n low at any time (including mid-WB), enter IDLE asynchronously: this_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, commit_pc=0, commit_cnt=0; the pending write is discarded.
REQ-027 SHALL assert this_ready=1 in the first cycle after reset release.

Configuration
REQ-028 SHALL, with macro COMMIT_CNT_EN defined, increment commit_cnt by 1 on every commit handshake, wrapping at 2^64.
REQ-029 SHALL, without COMMIT_CNT_EN, tie commit_cnt to 0 and contain no counter flops.

Verification
REQ-030 SHALL cover: reset, then addi rd=5, wb_sel=0, alu_result=0x1234, prev_valid 1 cycle, next_ready=1 -> rf_wen one cycle, rf_waddr=5, rf_wdata=0x1234, this_valid one cycle.
REQ-031 SHALL cover: jal rd=1, pc=0x80000000, wb_sel=2 -> rf_wdata=0x80000004; pc=0xFFFFFFFC -> rf_wdata=0x00000000.
REQ-032 SHALL cover: lw rd=0, reg_wen=1, wb_sel=1 -> rf_wen stays 0, this_valid still 1 and commit occurs.
REQ-033 SHALL cover: next_ready low 5 cycles after accept -> rf_wen pulses once, this_valid high 6 cycles, this_ready low while stalled, second prev_valid not accepted.
REQ-034 SHALL cover: prev_valid and next_ready high 4 consecutive cycles -> 4 rf_wen pulses in 4 cycles; commit_cnt=4 with COMMIT_CNT_EN, 0 without.
REQ-035 SHALL cover: rst_n low during WB with next_ready low -> all outputs 0 immediately, no further rf_wen, this_ready=1 after release.

Source files
------------

// File: rtl/wbu.sv
// -----------------------------------------------------------------------------
// wbu -- write-back unit
//
// Last pipeline stage. Accepts one instruction at a time from the LSU stage,
// selects the register-file write data, writes rd exactly once (in the first
// cycle after accept) and then presents the instruction as committed
// (this_valid) until the downstream side takes it (next_ready). While a
// commit handshake happens, a new instruction may be accepted in the same
// cycle, so the unit sustains one instruction per cycle.
//
// Optional feature: define macro COMMIT_CNT_EN to build a 64-bit retired
// instruction counter on commit_cnt. Without it commit_cnt is tied to 0
// and no counter flops exist.
//
// Parameters:
//   XLEN        width of PC and register-file write data (default 32)
//
// Ports:
//   clk         in   1     core clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   inst        in   32    instruction; rd = inst[11:7]
//   pc          in   XLEN  PC of inst
//   alu_result  in   XLEN  write-back source 0
//   lsu_rdata   in   XLEN  write-back source 1
//   csr_rdata   in   XLEN  write-back source 3 (source 2 is pc+4)
//   wb_sel      in   2     write-back source select
//   reg_wen     in   1     instruction writes rd
//   prev_valid  in   1     LSU has an instruction for us
//   this_ready  out  1     we can take an instruction this cycle
//   this_valid  out  1     an instruction is waiting to commit
//   next_ready  in   1     downstream takes the committing instruction
//   rf_wen      out  1     register-file write enable (single-cycle pulse)
//   rf_waddr    out  5     register-file write address
//   rf_wdata    out  XLEN  register-file write data
//   commit_pc   out  XLEN  PC of the committing instruction
//   commit_cnt  out  64    retired instruction count (0 when disabled)
// -----------------------------------------------------------------------------
module wbu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] lsu_rdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [1:0]      wb_sel,
  input  logic            reg_wen,
  input  logic            prev_valid,
  output logic            this_ready,
  output logic            this_valid,
  input  logic            next_ready,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] commit_pc,
  output logic [63:0]     commit_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WB   = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_this_valid;
  logic              r_rf_wen;
  logic [4:0]        r_rf_waddr;
  logic [XLEN-1:0]   r_rf_wdata;
  logic [XLEN-1:0]   r_commit_pc;

  logic              w_accept;
  logic              w_commit;
  logic [4:0]        w_rd;
  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_sel_data;
  logic              w_do_write;

  // Only rd is meaningful here; the remaining instruction bits are decoded
  // upstream and intentionally ignored.
  logic              w_unused_inst_bits;
  assign w_unused_inst_bits = ^{inst[31:12], inst[6:0]};

  assign w_rd       = inst[11:7];
  assign w_pc_plus4 = pc + XLEN'(4);   // wraps modulo 2^XLEN
  assign w_do_write = reg_wen & (w_rd != 5'd0);

  always_comb begin
    w_sel_data = alu_result;
    case (wb_sel)
      2'd0:    w_sel_data = alu_result;
      2'd1:    w_sel_data = lsu_rdata;
      2'd2:    w_sel_data = w_pc_plus4;
      2'd3:    w_sel_data = csr_rdata;
      default: w_sel_data = alu_result;
    endcase
  end

  // Ready when empty, or when the held instruction leaves this very cycle.
  assign this_ready = (r_state == S_IDLE) | (r_this_valid & next_ready);
  assign w_accept   = prev_valid & this_ready;
  assign w_commit   = r_this_valid & next_ready;

  // Single FSM block: state plus every registered output.
  // rf_wen defaults low each cycle so it can only be high in the cycle right
  // after an accept; a stall (next_ready low) therefore never rewrites rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_this_valid <= 1'b0;
      r_rf_wen     <= 1'b0;
      r_rf_waddr   <= 5'd0;
      r_rf_wdata   <= '0;
      r_commit_pc  <= '0;
    end else begin
      r_rf_wen <= 1'b0;

      // Capture happens only on accept; otherwise the outputs hold, which
      // keeps waddr/wdata/commit_pc stable across any stall.
      if (w_accept) begin
        r_rf_waddr  <= w_rd;
        r_rf_wdata  <= w_sel_data;
        r_commit_pc <= pc;
        r_rf_wen    <= w_do_write;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_WB;
            r_this_valid <= 1'b1;
          end
        end
        S_WB: begin
          // In WB an accept is only possible together with a commit, so
          // staying in WB here is the back-to-back case.
          if (w_accept) begin
            r_state      <= S_WB;
            r_this_valid <= 1'b1;
          end else if (w_commit) begin
            r_state      <= S_IDLE;
            r_this_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_this_valid <= 1'b0;
        end
      endcase
    end
  end

  assign this_valid = r_this_valid;
  assign rf_wen     = r_rf_wen;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign commit_pc  = r_commit_pc;

`ifdef COMMIT_CNT_EN
  logic [63:0] r_commit_cnt;

  // Free-running retire counter; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_cnt <= 64'd0;
    end else if (w_commit) begin
      r_commit_cnt <= r_commit_cnt + 64'd1;
    end
  end

  assign commit_cnt = r_commit_cnt;
`else
  assign commit_cnt = 64'd0;
`endif

endmodule
